// File: rtl/audio_dac_serializer.sv
// ============================================================================
//  Module      : audio_dac_serializer
//  Description : Parallel L/R samples to WM8731 left-justified DAC bus (master).
//                Optional MUTE input when AUDIO_DAC_MUTE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_dac_serializer #(
    parameter int DATA_WIDTH       = 16,
    parameter int BITS_PER_CHANNEL = 32,
    parameter int BCLK_HALF_CYCLES = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic [DATA_WIDTH-1:0] DAC_LCHAN_DATA,
    input  logic [DATA_WIDTH-1:0] DAC_RCHAN_DATA,
    input  logic                  SAMPLE_VALID,
`ifdef AUDIO_DAC_MUTE_EN
    input  logic                  MUTE,
`endif
    output logic                  SAMPLE_LOAD,
    output logic                  SAMPLE_UNDERRUN,
    output logic                  AUD_BCLK,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT
);

    localparam int c_DIV_W = (BCLK_HALF_CYCLES > 1) ? $clog2(BCLK_HALF_CYCLES) : 1;
    localparam int c_BIT_W = $clog2(2 * BITS_PER_CHANNEL);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST     = c_DIV_W'(BCLK_HALF_CYCLES - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST     = c_BIT_W'(2 * BITS_PER_CHANNEL - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LEFT_END = c_BIT_W'(BITS_PER_CHANNEL - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_DIV_W-1:0]      r_div_cnt;
    logic [c_BIT_W-1:0]      r_bit_cnt;
    logic                    r_bclk;
    logic                    r_lrck;
    logic                    r_dat;
    logic                    r_load;
    logic                    r_underrun;
    logic [DATA_WIDTH-1:0]   r_hold_l;
    logic [DATA_WIDTH-1:0]   r_hold_r;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   r_right;

    logic                    w_mute;
    logic                    w_div_last;
    logic                    w_bclk_fall;
    logic                    w_frame_start;
    logic [DATA_WIDTH-1:0]   w_new_l;
    logic [DATA_WIDTH-1:0]   w_new_r;
    logic [DATA_WIDTH-1:0]   w_load_l;
    logic [DATA_WIDTH-1:0]   w_load_r;
    logic [DATA_WIDTH-1:0]   w_shift_next;

`ifdef AUDIO_DAC_MUTE_EN
    assign w_mute = MUTE;
`else
    assign w_mute = 1'b0;
`endif

    assign w_div_last    = (r_div_cnt == c_DIV_LAST);
    assign w_bclk_fall   = (r_state == S_RUN) && w_div_last && r_bclk;
    assign w_frame_start = ENABLE && ((r_state == S_IDLE) ||
                                      (w_bclk_fall && (r_bit_cnt == c_BIT_LAST)));

    // Missing samples repeat the last held pair; mute only affects what is shifted out.
    assign w_new_l      = SAMPLE_VALID ? DAC_LCHAN_DATA : r_hold_l;
    assign w_new_r      = SAMPLE_VALID ? DAC_RCHAN_DATA : r_hold_r;
    assign w_load_l     = w_mute ? '0 : w_new_l;
    assign w_load_r     = w_mute ? '0 : w_new_r;
    assign w_shift_next = r_shift << 1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!ENABLE) begin
            w_state_next = S_IDLE;
        end else begin
            w_state_next = S_RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || !ENABLE) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_bclk     <= 1'b0;
            r_lrck     <= 1'b0;
            r_dat      <= 1'b0;
            r_load     <= 1'b0;
            r_underrun <= 1'b0;
            r_hold_l   <= '0;
            r_hold_r   <= '0;
            r_shift    <= '0;
            r_right    <= '0;
        end else begin
            r_load     <= 1'b0;
            r_underrun <= 1'b0;

            if (r_state == S_IDLE) begin
                r_div_cnt <= '0;
                r_bclk    <= 1'b0;
            end else if (w_div_last) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            if (w_frame_start) begin
                r_bit_cnt  <= '0;
                r_lrck     <= 1'b1;
                r_load     <= 1'b1;
                r_underrun <= ~SAMPLE_VALID;
                r_hold_l   <= w_new_l;
                r_hold_r   <= w_new_r;
                r_shift    <= w_load_l;
                r_right    <= w_load_r;
                r_dat      <= w_load_l[DATA_WIDTH-1];
            end else if (w_bclk_fall) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                // Right half starts from the copy frozen at frame start, so no tearing.
                if (r_bit_cnt == c_BIT_LEFT_END) begin
                    r_lrck  <= 1'b0;
                    r_shift <= r_right;
                    r_dat   <= r_right[DATA_WIDTH-1];
                end else begin
                    r_shift <= w_shift_next;
                    r_dat   <= w_shift_next[DATA_WIDTH-1];
                end
            end
        end
    end

    assign SAMPLE_LOAD     = r_load;
    assign SAMPLE_UNDERRUN = r_underrun;
    assign AUD_BCLK        = r_bclk;
    assign AUD_DACLRCK     = r_lrck;
    assign AUD_DACDAT      = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_audio_dac_serializer.sv
// ============================================================================
//  Module      : tb_audio_dac_serializer
//  Description : Directed self-checking bench for audio_dac_serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_dac_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] lchan;
    logic [15:0] rchan;
    logic        valid;
`ifdef AUDIO_DAC_MUTE_EN
    logic        mute;
`endif
    logic        sample_load;
    logic        sample_underrun;
    logic        bclk;
    logic        lrck;
    logic        dacdat;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    audio_dac_serializer dut (
        .CLK             (clk),
        .RESET           (rst),
        .ENABLE          (enable),
        .DAC_LCHAN_DATA  (lchan),
        .DAC_RCHAN_DATA  (rchan),
        .SAMPLE_VALID    (valid),
`ifdef AUDIO_DAC_MUTE_EN
        .MUTE            (mute),
`endif
        .SAMPLE_LOAD     (sample_load),
        .SAMPLE_UNDERRUN (sample_underrun),
        .AUD_BCLK        (bclk),
        .AUD_DACLRCK     (lrck),
        .AUD_DACDAT      (dacdat)
    );

    // Wait for the next SAMPLE_LOAD pulse; reports CLKs waited and UNDERRUN at that cycle.
    task automatic wait_load(output int waited, output logic und, output bit ok);
        waited = 0;
        und    = 1'b0;
        ok     = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            waited++;
            if (sample_load === 1'b1) begin
                und = sample_underrun;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    // Recover one frame (64 bits) as the codec would, on BCLK rising edges.
    task automatic capture_frame(output logic [63:0] bits, output logic [63:0] lr,
                                 output int unds, output bit ok);
        logic prev;
        int   n;
        bits = '0;
        lr   = '0;
        unds = 0;
        ok   = 1'b0;
        n    = 0;
        prev = bclk;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (sample_underrun === 1'b1) unds++;
            if (bclk === 1'b1 && prev === 1'b0) begin
                bits[63-n] = dacdat;
                lr[63-n]   = lrck;
                n++;
            end
            prev = bclk;
            if (n == 64) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        enable = 1'b1;
        valid  = 1'b1;
        lchan  = 16'hA5C3;
        rchan  = 16'h8001;
`ifdef AUDIO_DAC_MUTE_EN
        mute   = 1'b0;
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bclk, lrck, dacdat, sample_load, sample_underrun} !== 5'b0)
                $display("FAIL reset_outputs cycle %0d: got %b expected 00000", i,
                         {bclk, lrck, dacdat, sample_load, sample_underrun});
            if ({bclk, lrck, dacdat, sample_load, sample_underrun} !== 5'b0) errors++;
        end
        rst = 1'b0;
    endtask

    task automatic test_serial_data;
        int          w;
        logic        und;
        bit          ok;
        logic [63:0] bits;
        logic [63:0] lr;
        int          unds;
        wait_load(w, und, ok);
        checks++;
        if (!ok || w != 1) begin
            errors++;
            $display("FAIL first_load: got ok=%0d after %0d clks, expected ok=1 after 1", ok, w);
        end
        capture_frame(bits, lr, unds, ok);
        checks++;
        if (!ok || bits !== {16'hA5C3, 16'h0000, 16'h8001, 16'h0000}) begin
            errors++;
            $display("FAIL frame_bits: got %h expected a5c3000080010000", bits);
        end
        checks++;
        if (lr !== {32'hFFFF_FFFF, 32'h0}) begin
            errors++;
            $display("FAIL lrck_pattern: got %h expected ffffffff00000000", lr);
        end
    endtask

    task automatic test_frame_timing;
        int   w;
        logic und;
        bit   ok;
        int   hi;
        int   lo;
        wait_load(w, und, ok);
        for (int f = 0; f < 3; f++) begin
            wait_load(w, und, ok);
            checks++;
            if (!ok || w != 1024) begin
                errors++;
                $display("FAIL load_spacing %0d: got %0d clks expected 1024", f, w);
            end
        end
        hi = 0;
        lo = 0;
        for (int i = 0; i < 40 && bclk !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 40 && bclk === 1'b1; i++) begin
            hi++;
            @(negedge clk);
        end
        for (int i = 0; i < 40 && bclk === 1'b0; i++) begin
            lo++;
            @(negedge clk);
        end
        checks++;
        if (hi != 8 || lo != 8) begin
            errors++;
            $display("FAIL bclk_duty: got high=%0d low=%0d expected 8/8", hi, lo);
        end
    endtask

    task automatic test_underrun;
        int          w;
        logic        und;
        bit          ok;
        logic [63:0] bits;
        logic [63:0] lr;
        int          unds;
        lchan = 16'h7FFF;
        rchan = 16'h1234;
        valid = 1'b1;
        wait_load(w, und, ok);
        valid = 1'b0;
        lchan = 16'h0BAD;
        rchan = 16'h0BAD;
        wait_load(w, und, ok);
        checks++;
        if (!ok || und !== 1'b1) begin
            errors++;
            $display("FAIL underrun_pulse: got %b expected 1", und);
        end
        capture_frame(bits, lr, unds, ok);
        checks++;
        if (!ok || bits !== {16'h7FFF, 16'h0000, 16'h1234, 16'h0000}) begin
            errors++;
            $display("FAIL underrun_repeat: got %h expected 7fff000012340000", bits);
        end
        checks++;
        if (unds != 0) begin
            errors++;
            $display("FAIL underrun_once: got %0d extra pulses expected 0", unds);
        end
        valid = 1'b1;
    endtask

    task automatic test_no_tear;
        int          w;
        logic        und;
        bit          ok;
        logic [63:0] bits;
        logic [63:0] lr;
        int          unds;
        lchan = 16'h0000;
        rchan = 16'h00F0;
        wait_load(w, und, ok);
        wait_load(w, und, ok);
        fork
            capture_frame(bits, lr, unds, ok);
            begin
                repeat (100) @(negedge clk);
                lchan = 16'hFFFF;
            end
        join
        checks++;
        if (!ok || bits !== {16'h0000, 16'h0000, 16'h00F0, 16'h0000}) begin
            errors++;
            $display("FAIL no_tear_current: got %h expected 0000000000f00000", bits);
        end
        wait_load(w, und, ok);
        capture_frame(bits, lr, unds, ok);
        checks++;
        if (!ok || bits !== {16'hFFFF, 16'h0000, 16'h00F0, 16'h0000}) begin
            errors++;
            $display("FAIL no_tear_next: got %h expected ffff000000f00000", bits);
        end
    endtask

    task automatic test_enable_abort;
        int          w;
        logic        und;
        bit          ok;
        logic [63:0] bits;
        logic [63:0] lr;
        int          unds;
        logic        bad;
        lchan = 16'h1357;
        rchan = 16'h0080;
        wait_load(w, und, ok);
        wait_load(w, und, ok);
        repeat (645) @(negedge clk);
        checks++;
        if ({lrck, dacdat} !== 2'b01) begin
            errors++;
            $display("FAIL bit40_state: got lrck/dat=%b expected 01", {lrck, dacdat});
        end
        enable = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({bclk, lrck, dacdat, sample_load, sample_underrun} !== 5'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL disable_outputs: got nonzero outputs expected 00000");
        end
        valid  = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if ({bclk, lrck, dacdat, sample_load, sample_underrun} !== 5'b01011) begin
            errors++;
            $display("FAIL reenable_start: got %b expected 01011",
                     {bclk, lrck, dacdat, sample_load, sample_underrun});
        end
        capture_frame(bits, lr, unds, ok);
        checks++;
        if (!ok || bits !== 64'h0 || lr !== {32'hFFFF_FFFF, 32'h0}) begin
            errors++;
            $display("FAIL reenable_frame: got bits=%h lr=%h expected 0 / ffffffff00000000",
                     bits, lr);
        end
        valid = 1'b1;
    endtask

`ifdef AUDIO_DAC_MUTE_EN
    task automatic test_mute;
        int          w;
        logic        und;
        bit          ok;
        logic [63:0] bits;
        logic [63:0] lr;
        int          unds;
        lchan = 16'hFFFF;
        rchan = 16'hFFFF;
        mute  = 1'b1;
        wait_load(w, und, ok);
        capture_frame(bits, lr, unds, ok);
        checks++;
        if (!ok || bits !== 64'h0) begin
            errors++;
            $display("FAIL mute_frame: got %h expected 0", bits);
        end
        mute = 1'b0;
        wait_load(w, und, ok);
        capture_frame(bits, lr, unds, ok);
        checks++;
        if (!ok || bits !== {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000}) begin
            errors++;
            $display("FAIL unmute_frame: got %h expected ffff0000ffff0000", bits);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_serial_data();
        test_frame_timing();
        test_underrun();
        test_no_tear();
        test_enable_abort();
`ifdef AUDIO_DAC_MUTE_EN
        test_mute();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
